io_mmio_unit: RTL and testbench
===============================

Name: io_mmio_unit

Overview:
Parametrised memory-mapped I/O unit for the eLC-3. It replaces the fixed KBDR/KBSR/DDR/DSR set in the memory control path with two pieces: a keyboard input FIFO of configurable depth, and NUM_DISP display data registers that carry a display-busy model. It sits between the datapath bus signals (Address, MIO_EN, R_W) and the board-level switch and hex-display logic. It also tells the memory path when an access hits device space.

Parameters:
DATA_W, 16, bus and register data width
ADDR_W, 16, CPU address width
NUM_DISP, 4, number of display data registers (1..8)
KBD_DEPTH, 4, keyboard FIFO depth; power of 2, minimum 2
BUSY_CYCLES, 8, cycles DSR stays not-ready after an accepted DDR write (minimum 1)
KBSR_ADDR, 16'hFE00, keyboard status register address
KBDR_ADDR, 16'hFE02, keyboard data register address
DSR_ADDR, 16'hFE04, display status register address
DDR_BASE, 16'hFE06, address of DDR0; DDRi is at DDR_BASE+i

Ports:
Clk  in  1  system clock, rising edge
Reset_N  in  1  asynchronous active-low reset
Address  in  ADDR_W  CPU memory address
MIO_EN  in  1  memory/IO access strobe, one cycle per access
R_W  in  1  1 = write, 0 = read
Data_FromCPU  in  DATA_W  write data
Data_ToCPU  out  DATA_W  registered read data
Is_Device  out  1  combinational; 1 when Address decodes to any register of this unit
Key_Data  in  DATA_W  synchronised switch value
Key_Strobe  in  1  synchronised key level; a rising edge captures Key_Data
Disp_Out  out  NUM_DISP*DATA_W  concatenated DDRs; DDR0 in the LSBs
Kbd_Overflow  out  1  mirror of the sticky KBSR[14]

Behaviour:
- Reset (asynchronous, while Reset_N=0):
  - FIFO empty, count 0; overflow flag 0.
  - All DDRs 0; DSR ready = 1; busy counter 0; dropped-write flag 0.
  - Data_ToCPU = 0.
  - Strobe edge register = 1, so a key held at reset release produces no push.
- Access: occurs in any cycle with MIO_EN=1 and Is_Device=1. When Is_Device=0, the unit has no side effects.
- Read latency: 1 cycle. Data_ToCPU is loaded on the clock edge ending the read cycle and holds until the next device read. It is loaded with 0 on a non-device MIO_EN read.
- KBSR read value:
  - bit15 = FIFO non-empty
  - bit14 = overflow
  - bits[13:0] = entry count, zero-extended
- KBSR write: bit14=1 clears overflow (write-1-to-clear). All other bits are ignored.
- KBDR read:
  - Non-empty: returns the head entry and pops it in the same cycle.
  - Empty: returns 0, no pop.
- KBDR write: ignored.
- Push: when Key_Strobe=1 and the previous-cycle value was 0, Key_Data is pushed.
  - If the FIFO is full and no pop occurs that cycle: the data is dropped and overflow is set to 1.
- Simultaneous push and pop:
  - Both take effect; count is unchanged.
  - When full, the push is accepted and overflow is not set.
  - When empty, the read returns 0 and the push is accepted (reads see pre-edge state).
- Pointers wrap modulo KBD_DEPTH. Count ranges 0..KBD_DEPTH.
- DSR read value: bit15 = ready, bit14 = dropped-write flag, other bits 0.
- DSR write: bit14=1 clears the dropped-write flag (write-1-to-clear).
- DDRi write:
  - If ready: load the DDR, set ready=0, load the busy counter with BUSY_CYCLES.
  - If not ready: ignored, dropped-write flag set to 1.
- Busy counter: decrements each cycle while nonzero. Ready returns to 1 in the cycle the counter reaches 0, so DSR[15]=0 for exactly BUSY_CYCLES cycles after the write edge.
- DDRi read: returns its value, with no side effects.
- Addresses in device range: KBSR, KBDR, DSR, DDR_BASE..DDR_BASE+NUM_DISP-1. All other addresses give Is_Device=0.
- Disp_Out updates on the clock edge of the accepted write.

Test Plan:
- Reset, then KBSR read -> Data_ToCPU=16'h0000 next cycle; DSR read -> 16'h8000; Disp_Out=0.
- Four strobe edges with Key_Data 1,2,3,4 (KBD_DEPTH=4), then KBSR read -> 16'h8004. Four KBDR reads -> 1,2,3,4; KBSR -> 16'h0000.
- Fifth edge while full with Key_Data=16'h00AA -> KBSR=16'hC004, Kbd_Overflow=1, 16'h00AA never read. Write KBSR=16'h4000 -> KBSR=16'h8004.
- With the FIFO full, a strobe edge in the same cycle as a KBDR read -> head returned, count stays 4, no overflow. With the FIFO empty, the same collision -> read returns 0, count becomes 1.
- Write DDR2=16'h1234 -> Disp_Out[47:32]=16'h1234 and DSR=0 for 8 cycles, then 16'h8000. A DDR0 write during busy -> DDR0 unchanged, DSR=16'h4000 while busy.
- Reset_N asserted mid-busy with FIFO count 2 -> everything cleared immediately (not at the next clock edge); key held high across reset release -> no push.

Source files
------------

// File: rtl/io_mmio_unit.sv
// Memory-mapped keyboard FIFO, display status and display data registers for the eLC-3 bus.
// Latency: reads return registered data one cycle after the access; Is_Device decodes combinationally.
// Backpressure: none; a full keyboard FIFO drops keys and sets a sticky flag, and busy displays drop writes.
module io_mmio_unit #(
  parameter int                DATA_W      = 16,
  parameter int                ADDR_W      = 16,
  parameter int                NUM_DISP    = 4,
  parameter int                KBD_DEPTH   = 4,
  parameter int                BUSY_CYCLES = 8,
  parameter logic [ADDR_W-1:0] KBSR_ADDR   = 16'hFE00,
  parameter logic [ADDR_W-1:0] KBDR_ADDR   = 16'hFE02,
  parameter logic [ADDR_W-1:0] DSR_ADDR    = 16'hFE04,
  parameter logic [ADDR_W-1:0] DDR_BASE    = 16'hFE06
) (
  input  logic                       Clk,
  input  logic                       Reset_N,
  input  logic [ADDR_W-1:0]          Address,
  input  logic                       MIO_EN,
  input  logic                       R_W,
  input  logic [DATA_W-1:0]          Data_FromCPU,
  output logic [DATA_W-1:0]          Data_ToCPU,
  output logic                       Is_Device,
  input  logic [DATA_W-1:0]          Key_Data,
  input  logic                       Key_Strobe,
  output logic [NUM_DISP*DATA_W-1:0] Disp_Out,
  output logic                       Kbd_Overflow
);

  localparam int PTR_W  = $clog2(KBD_DEPTH);
  localparam int CNT_W  = $clog2(KBD_DEPTH + 1);
  localparam int BUSY_W = $clog2(BUSY_CYCLES + 1);
  localparam int DIDX_W = (NUM_DISP > 1) ? $clog2(NUM_DISP) : 1;

  logic [DATA_W-1:0] fifo_mem [KBD_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              overflow;
  logic              strobe_q;
  logic [DATA_W-1:0] ddr [NUM_DISP];
  logic [BUSY_W-1:0] busy_cnt;
  logic              dropped;

  logic [ADDR_W-1:0] ddr_off;
  logic [DIDX_W-1:0] ddr_idx;
  logic              hit_kbsr, hit_kbdr, hit_dsr, hit_ddr;
  logic              access, dev_wr, dev_rd;
  logic              kbd_empty, kbd_full, ready;
  logic              push_edge, push, pop, ovf_set, ovf_clr;
  logic              ddr_wr, dsr_clr;
  logic [DATA_W-1:0] rd_val;

  // Address decode; DDR hit uses an unsigned offset so addresses below the base wrap high and miss.
  assign ddr_off   = Address - DDR_BASE;
  assign ddr_idx   = ddr_off[DIDX_W-1:0];
  assign hit_kbsr  = (Address == KBSR_ADDR);
  assign hit_kbdr  = (Address == KBDR_ADDR);
  assign hit_dsr   = (Address == DSR_ADDR);
  assign hit_ddr   = (ddr_off < ADDR_W'(NUM_DISP));
  assign Is_Device = hit_kbsr | hit_kbdr | hit_dsr | hit_ddr;

  assign access = MIO_EN & Is_Device;
  assign dev_wr = access & R_W;
  assign dev_rd = access & ~R_W;

  assign kbd_empty = (count == '0);
  assign kbd_full  = (count == CNT_W'(KBD_DEPTH));
  assign ready     = (busy_cnt == '0);

  // A pop in the same cycle frees the slot, so a push into a full FIFO is accepted then.
  assign pop       = dev_rd & hit_kbdr & ~kbd_empty;
  assign push_edge = Key_Strobe & ~strobe_q;
  assign push      = push_edge & (~kbd_full | pop);
  assign ovf_set   = push_edge & kbd_full & ~pop;
  assign ovf_clr   = dev_wr & hit_kbsr & Data_FromCPU[DATA_W-2];
  assign ddr_wr    = dev_wr & hit_ddr;
  assign dsr_clr   = dev_wr & hit_dsr & Data_FromCPU[DATA_W-2];

  assign Kbd_Overflow = overflow;

  // Read mux over pre-edge state.
  always_comb begin
    rd_val = '0;
    if (hit_kbsr) begin
      rd_val[DATA_W-1]  = ~kbd_empty;
      rd_val[DATA_W-2]  = overflow;
      rd_val[CNT_W-1:0] = count;
    end else if (hit_kbdr) begin
      if (!kbd_empty) rd_val = fifo_mem[rd_ptr];
    end else if (hit_dsr) begin
      rd_val[DATA_W-1] = ready;
      rd_val[DATA_W-2] = dropped;
    end else if (hit_ddr) begin
      rd_val = ddr[ddr_idx];
    end
  end

  // Keyboard FIFO control: strobe edge detect, pointers, count and sticky overflow.
  always_ff @(posedge Clk or negedge Reset_N) begin
    if (!Reset_N) begin
      strobe_q <= 1'b1;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      strobe_q <= Key_Strobe;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // Setting wins over a same-cycle clear so a freshly lost key is never hidden.
      if (ovf_set)      overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
    end
  end

  // FIFO storage; contents are don't-care while count says empty.
  always_ff @(posedge Clk) begin
    if (push) fifo_mem[wr_ptr] <= Key_Data;
  end

  // Display registers and busy model; ready is simply the busy counter at zero.
  always_ff @(posedge Clk or negedge Reset_N) begin
    if (!Reset_N) begin
      for (int i = 0; i < NUM_DISP; i++) ddr[i] <= '0;
      busy_cnt <= '0;
      dropped  <= 1'b0;
    end else begin
      if (ddr_wr && ready) begin
        ddr[ddr_idx] <= Data_FromCPU;
        busy_cnt     <= BUSY_W'(BUSY_CYCLES);
      end else if (!ready) begin
        busy_cnt <= busy_cnt - 1'b1;
      end
      if (ddr_wr && !ready) dropped <= 1'b1;
      else if (dsr_clr)     dropped <= 1'b0;
    end
  end

  // Read data register: loads on any MIO read, zero when the address is not ours.
  always_ff @(posedge Clk or negedge Reset_N) begin
    if (!Reset_N) begin
      Data_ToCPU <= '0;
    end else if (MIO_EN && !R_W) begin
      Data_ToCPU <= Is_Device ? rd_val : '0;
    end
  end

  // Flatten the display registers, DDR0 in the least significant slice.
  always_comb begin
    Disp_Out = '0;
    for (int i = 0; i < NUM_DISP; i++) Disp_Out[i*DATA_W +: DATA_W] = ddr[i];
  end

endmodule

// File: tb/tb_io_mmio_unit.sv
// Self-checking bench for io_mmio_unit with default parameters.
// Table rows are one bus cycle each; busy-timing and reset sequences are written out by hand.
// Inputs change 1ns after the rising edge and outputs are sampled there too.
module tb_io_mmio_unit;

  localparam logic [15:0] KBSR = 16'hFE00;
  localparam logic [15:0] KBDR = 16'hFE02;
  localparam logic [15:0] DSR  = 16'hFE04;
  localparam logic [15:0] DDR0 = 16'hFE06;

  logic        Clk;
  logic        Reset_N;
  logic [15:0] Address;
  logic        MIO_EN;
  logic        R_W;
  logic [15:0] Data_FromCPU;
  logic [15:0] Data_ToCPU;
  logic        Is_Device;
  logic [15:0] Key_Data;
  logic        Key_Strobe;
  logic [63:0] Disp_Out;
  logic        Kbd_Overflow;

  int checks = 0;
  int errors = 0;

  io_mmio_unit dut (
    .Clk(Clk), .Reset_N(Reset_N), .Address(Address), .MIO_EN(MIO_EN), .R_W(R_W),
    .Data_FromCPU(Data_FromCPU), .Data_ToCPU(Data_ToCPU), .Is_Device(Is_Device),
    .Key_Data(Key_Data), .Key_Strobe(Key_Strobe), .Disp_Out(Disp_Out),
    .Kbd_Overflow(Kbd_Overflow)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic        mio;
    logic        rw;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        strobe;
    logic [15:0] key;
    logic        exp_dev;
    logic        chk_rd;
    logic [15:0] exp_rd;
    logic        exp_ovf;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic add(input logic mio, input logic rw, input logic [15:0] addr,
                     input logic [15:0] wdata, input logic strobe, input logic [15:0] key,
                     input logic dev, input logic chk_rd, input logic [15:0] exp_rd,
                     input logic ovf);
    vec_t v;
    v.mio = mio; v.rw = rw; v.addr = addr; v.wdata = wdata; v.strobe = strobe;
    v.key = key; v.exp_dev = dev; v.chk_rd = chk_rd; v.exp_rd = exp_rd; v.exp_ovf = ovf;
    vecs.push_back(v);
  endtask

  task automatic add_rd(input logic [15:0] addr, input logic dev, input logic [15:0] exp_rd,
                        input logic ovf);
    add(1'b1, 1'b0, addr, 16'h0, 1'b0, 16'h0, dev, 1'b1, exp_rd, ovf);
  endtask

  task automatic add_wr(input logic [15:0] addr, input logic [15:0] data, input logic ovf);
    add(1'b1, 1'b1, addr, data, 1'b0, 16'h0, 1'b1, 1'b0, 16'h0, ovf);
  endtask

  task automatic add_key(input logic [15:0] k, input logic ovf);
    add(1'b0, 1'b0, 16'h0000, 16'h0, 1'b1, k, 1'b0, 1'b0, 16'h0, ovf);
    add(1'b0, 1'b0, 16'h0000, 16'h0, 1'b0, k, 1'b0, 1'b0, 16'h0, ovf);
  endtask

  // One bus access lasting one cycle.
  task automatic bus(input logic rw, input logic [15:0] addr, input logic [15:0] wdata);
    MIO_EN = 1'b1; R_W = rw; Address = addr; Data_FromCPU = wdata;
    step();
    MIO_EN = 1'b0; R_W = 1'b0;
  endtask

  task automatic key_push(input logic [15:0] k);
    Key_Data = k; Key_Strobe = 1'b1;
    step();
    Key_Strobe = 1'b0;
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    bit seen;
    Reset_N = 1'b0; Address = 16'h0; MIO_EN = 1'b0; R_W = 1'b0;
    Data_FromCPU = 16'h0; Key_Data = 16'h0; Key_Strobe = 1'b0;
    step(); step();
    chk("reset_rd", Data_ToCPU, 16'h0);
    chk("reset_disp", Disp_Out, 64'h0);
    chk("reset_ovf", Kbd_Overflow, 1'b0);
    #2 Reset_N = 1'b1;
    step();

    // Reset state reads, FIFO fill and overflow.
    add_rd(KBSR, 1, 16'h0000, 0);
    add_rd(DSR,  1, 16'h8000, 0);
    add_key(16'h0001, 0);
    add_key(16'h0002, 0);
    add_key(16'h0003, 0);
    add_key(16'h0004, 0);
    add_rd(KBSR, 1, 16'h8004, 0);
    add(1'b0, 1'b0, 16'h0000, 16'h0, 1'b1, 16'h00AA, 1'b0, 1'b0, 16'h0, 1'b1);
    add_rd(KBSR, 1, 16'hC004, 1);
    add_wr(KBSR, 16'h4000, 0);
    add_rd(KBSR, 1, 16'h8004, 0);
    add_rd(KBDR, 1, 16'h0001, 0);
    add_rd(KBDR, 1, 16'h0002, 0);
    add_rd(KBDR, 1, 16'h0003, 0);
    add_rd(KBDR, 1, 16'h0004, 0);
    add_rd(KBSR, 1, 16'h0000, 0);
    add_rd(KBDR, 1, 16'h0000, 0);
    // Decode edges: non-device reads load zero.
    add_rd(DSR,  1, 16'h8000, 0);
    add_rd(16'hFE0A, 0, 16'h0000, 0);
    add_rd(DSR,  1, 16'h8000, 0);
    add_rd(16'hFE05, 0, 16'h0000, 0);
    add_rd(DSR,  1, 16'h8000, 0);
    add_rd(16'hFDFF, 0, 16'h0000, 0);
    add_rd(16'hFE01, 0, 16'h0000, 0);
    add_rd(16'hFE09, 1, 16'h0000, 0);
    add_wr(KBDR, 16'h1111, 0);
    add_rd(KBSR, 1, 16'h0000, 0);
    // Full FIFO: strobe edge together with a pop.
    add_key(16'h0005, 0);
    add_key(16'h0006, 0);
    add_key(16'h0007, 0);
    add_key(16'h0008, 0);
    add(1'b1, 1'b0, KBDR, 16'h0, 1'b1, 16'h0009, 1'b1, 1'b1, 16'h0005, 1'b0);
    add_rd(KBSR, 1, 16'h8004, 0);
    add_rd(KBDR, 1, 16'h0006, 0);
    add_rd(KBDR, 1, 16'h0007, 0);
    add_rd(KBDR, 1, 16'h0008, 0);
    add_rd(KBDR, 1, 16'h0009, 0);
    add_rd(KBSR, 1, 16'h0000, 0);
    // Empty FIFO: strobe edge together with a read.
    add(1'b1, 1'b0, KBDR, 16'h0, 1'b1, 16'h0055, 1'b1, 1'b1, 16'h0000, 1'b0);
    add_rd(KBSR, 1, 16'h8001, 0);
    add_rd(KBDR, 1, 16'h0055, 0);

    foreach (vecs[i]) begin
      MIO_EN = vecs[i].mio; R_W = vecs[i].rw; Address = vecs[i].addr;
      Data_FromCPU = vecs[i].wdata; Key_Strobe = vecs[i].strobe; Key_Data = vecs[i].key;
      #1;
      chk($sformatf("vec%0d_is_device", i), Is_Device, vecs[i].exp_dev);
      @(posedge Clk);
      #1;
      if (vecs[i].chk_rd) chk($sformatf("vec%0d_rdata", i), Data_ToCPU, vecs[i].exp_rd);
      chk($sformatf("vec%0d_overflow", i), Kbd_Overflow, vecs[i].exp_ovf);
    end
    MIO_EN = 1'b0; R_W = 1'b0; Key_Strobe = 1'b0;
    step();

    // DDR2 write: DSR not ready for exactly 8 cycles.
    bus(1'b1, DDR0 + 16'd2, 16'h1234);
    chk("ddr2_disp", Disp_Out[47:32], 16'h1234);
    for (int k = 0; k < 8; k++) begin
      bus(1'b0, DSR, 16'h0);
      chk($sformatf("dsr_busy_%0d", k), Data_ToCPU, 16'h0000);
    end
    bus(1'b0, DSR, 16'h0);
    chk("dsr_ready_again", Data_ToCPU, 16'h8000);

    // Write during busy is dropped and flagged.
    bus(1'b1, DDR0 + 16'd1, 16'hBEEF);
    bus(1'b1, DDR0, 16'h5555);
    bus(1'b0, DSR, 16'h0);
    chk("dsr_dropped_busy", Data_ToCPU, 16'h4000);
    chk("ddr0_unchanged", Disp_Out[15:0], 16'h0000);
    chk("ddr1_written", Disp_Out[31:16], 16'hBEEF);
    seen = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      bus(1'b0, DSR, 16'h0);
      seen = Data_ToCPU[15];
    end
    chk("dsr_ready_dropped", Data_ToCPU, 16'hC000);
    bus(1'b1, DSR, 16'h4000);
    bus(1'b0, DSR, 16'h0);
    chk("dsr_w1c", Data_ToCPU, 16'h8000);
    bus(1'b0, DDR0 + 16'd1, 16'h0);
    chk("ddr1_read", Data_ToCPU, 16'hBEEF);

    // Asynchronous reset mid-busy with two keys queued and key held across release.
    key_push(16'h0021);
    key_push(16'h0022);
    bus(1'b1, DDR0 + 16'd3, 16'h7777);
    bus(1'b0, DDR0 + 16'd3, 16'h0);
    chk("ddr3_read", Data_ToCPU, 16'h7777);
    Key_Data = 16'h0099; Key_Strobe = 1'b1;
    #2 Reset_N = 1'b0;
    #1;
    chk("async_rst_rd", Data_ToCPU, 16'h0);
    chk("async_rst_disp", Disp_Out, 64'h0);
    step();
    #2 Reset_N = 1'b1;
    step(); step();
    Key_Strobe = 1'b1;
    bus(1'b0, KBSR, 16'h0);
    chk("post_rst_kbsr", Data_ToCPU, 16'h0000);
    bus(1'b0, DSR, 16'h0);
    chk("post_rst_dsr", Data_ToCPU, 16'h8000);
    chk("post_rst_ovf", Kbd_Overflow, 1'b0);
    Key_Strobe = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
